// File: rtl/design_a_pkg.sv
// Shared definitions for the dual-core pin-linked MCU: instruction field layout,
// operand/opcode encodings, value limits and the saturation helper.
package design_a_pkg;

  localparam int DATA_W  = 11;
  localparam int INSTR_W = 24;
  localparam int PC_W    = 4;

  localparam int COND_HI  = 23;
  localparam int COND_LO  = 22;
  localparam int OP_HI    = 21;
  localparam int OP_LO    = 18;
  localparam int SRC_HI   = 17;
  localparam int SRC_LO   = 15;
  localparam int DST_HI   = 14;
  localparam int DST_LO   = 12;
  localparam int RSVD_BIT = 11;
  localparam int IMM_HI   = 10;
  localparam int IMM_LO   = 0;

  localparam int VAL_MAX = 999;
  localparam int VAL_MIN = -999;

  typedef enum logic [1:0] {
    COND_ALWAYS = 2'd0,
    COND_PLUS   = 2'd1,
    COND_MINUS  = 2'd2,
    COND_NEVER  = 2'd3
  } cond_e;

  typedef enum logic [3:0] {
    OP_NOP = 4'd0,
    OP_MOV = 4'd1,
    OP_ADD = 4'd2,
    OP_SUB = 4'd3,
    OP_MUL = 4'd4,
    OP_NOT = 4'd5,
    OP_TEQ = 4'd6,
    OP_TGT = 4'd7,
    OP_TLT = 4'd8,
    OP_SLP = 4'd9,
    OP_END = 4'd10
  } opcode_e;

  typedef enum logic [2:0] {
    SRC_IMM = 3'd0,
    SRC_ACC = 3'd1,
    SRC_DAT = 3'd2,
    SRC_IN  = 3'd3,
    SRC_OUT = 3'd4
  } src_e;

  typedef enum logic [2:0] {
    DST_ACC = 3'd0,
    DST_DAT = 3'd1,
    DST_OUT = 3'd2
  } dst_e;

  typedef enum logic [1:0] {
    FLAG_NONE  = 2'd0,
    FLAG_PLUS  = 2'd1,
    FLAG_MINUS = 2'd2
  } flag_e;

  // Clamp a full-precision result into the architectural value range.
  function automatic logic signed [DATA_W-1:0] sat(input int value);
    if (value > VAL_MAX) return DATA_W'(VAL_MAX);
    if (value < VAL_MIN) return DATA_W'(VAL_MIN);
    return DATA_W'(value);
  endfunction

endpackage

// File: rtl/design_a_mcu_core.sv
// One MCU core: read-only instruction memory, acc/dat registers, test flag,
// saturating ALU and tick-driven sleep counter. Executes one word per clk while awake.
module mcu_core
  import design_a_pkg::*;
#(
  parameter int IMEM_DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     tick,
  input  logic signed [DATA_W-1:0] in_pin,
  output logic signed [DATA_W-1:0] out_pin
);

  localparam int AW = (IMEM_DEPTH > 1) ? $clog2(IMEM_DEPTH) : 1;

  // Contents come only from a binary image preload or hierarchical preload; there is no write port.
  if (1) begin : instructionMemory
    logic [INSTR_W-1:0] memory [0:IMEM_DEPTH-1];
  end

  logic [PC_W-1:0]          program_counter;
  logic [INSTR_W-1:0]       final_instruction;
  logic signed [DATA_W-1:0] acc;
  logic signed [DATA_W-1:0] dat;
  flag_e                    flag;
  logic [DATA_W-1:0]        sleep_cnt;

  logic [PC_W-1:0]          pc_nxt;
  logic signed [DATA_W-1:0] acc_nxt;
  logic signed [DATA_W-1:0] dat_nxt;
  logic signed [DATA_W-1:0] out_nxt;
  flag_e                    flag_nxt;
  logic [DATA_W-1:0]        sleep_nxt;

  cond_e                    cond;
  opcode_e                  opcode;
  src_e                     src;
  dst_e                     dst;
  logic                     rsvd;
  logic signed [DATA_W-1:0] imm;
  logic signed [DATA_W-1:0] src_val;
  logic signed [DATA_W-1:0] mov_val;
  logic                     awake;
  logic                     run;

  assign final_instruction = instructionMemory.memory[program_counter[AW-1:0]];

  assign cond   = cond_e'(final_instruction[COND_HI:COND_LO]);
  assign opcode = opcode_e'(final_instruction[OP_HI:OP_LO]);
  assign src    = src_e'(final_instruction[SRC_HI:SRC_LO]);
  assign dst    = dst_e'(final_instruction[DST_HI:DST_LO]);
  assign rsvd   = final_instruction[RSVD_BIT];
  assign imm    = final_instruction[IMM_HI:IMM_LO];

  // A non-zero sleep count is the only sleeping condition.
  assign awake   = (sleep_cnt == '0);
  assign mov_val = sat(int'(src_val));

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    src_val = '0;
    case (src)
      SRC_IMM: src_val = imm;
      SRC_ACC: src_val = acc;
      SRC_DAT: src_val = dat;
      SRC_IN:  src_val = in_pin;
      SRC_OUT: src_val = out_pin;
      default: src_val = '0;
    endcase
  end

  always_comb begin
    run = 1'b0;
    case (cond)
      COND_ALWAYS: run = 1'b1;
      COND_PLUS:   run = (flag == FLAG_PLUS);
      COND_MINUS:  run = (flag == FLAG_MINUS);
      default:     run = 1'b0;
    endcase
    // Words with the reserved bit set are illegal and executed as NOP.
    if (rsvd) run = 1'b0;
  end

  always_comb begin
    pc_nxt    = program_counter;
    acc_nxt   = acc;
    dat_nxt   = dat;
    out_nxt   = out_pin;
    flag_nxt  = flag;
    sleep_nxt = sleep_cnt;

    if (!awake) begin
      if (tick) sleep_nxt = sleep_cnt - 1'b1;
    end else begin
      pc_nxt = (program_counter == PC_W'(IMEM_DEPTH - 1)) ? '0 : program_counter + 1'b1;
      if (run) begin
        case (opcode)
          OP_MOV: begin
            case (dst)
              DST_ACC: acc_nxt = mov_val;
              DST_DAT: dat_nxt = mov_val;
              DST_OUT: out_nxt = mov_val;
              default: ;
            endcase
          end
          OP_ADD: acc_nxt = sat(int'(acc) + int'(src_val));
          OP_SUB: acc_nxt = sat(int'(acc) - int'(src_val));
          OP_MUL: acc_nxt = sat(int'(acc) * int'(src_val));
          OP_NOT: acc_nxt = (acc == '0) ? DATA_W'(100) : '0;
          OP_TEQ: flag_nxt = (acc == src_val) ? FLAG_PLUS : FLAG_MINUS;
          OP_TGT: flag_nxt = (acc > src_val) ? FLAG_PLUS : FLAG_MINUS;
          OP_TLT: flag_nxt = (acc < src_val) ? FLAG_PLUS : FLAG_MINUS;
          OP_SLP: if (src_val > 0) sleep_nxt = src_val;
          OP_END: sleep_nxt = DATA_W'(1);
          default: ;
        endcase
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so all cores sample pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: instruction memory is deliberately absent here; reset must preserve the program.
      program_counter <= '0;
      acc             <= '0;
      dat             <= '0;
      out_pin         <= '0;
      flag            <= FLAG_NONE;
      sleep_cnt       <= '0;
    end else begin
      program_counter <= pc_nxt;
      acc             <= acc_nxt;
      dat             <= dat_nxt;
      out_pin         <= out_nxt;
      flag            <= flag_nxt;
      sleep_cnt       <= sleep_nxt;
    end
  end

endmodule

// File: rtl/design_a.sv
// Two MCU cores chained by their pins: input_signal -> dut0 -> dut1 -> output_signal.
// output_signal is dut1's out_pin register, so it is 0 throughout reset.
module design_a
  import design_a_pkg::*;
#(
  parameter int IMEM_DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     posedge_big_clk,
  input  logic signed [DATA_W-1:0] input_signal,
  output logic signed [DATA_W-1:0] output_signal
);

  logic signed [DATA_W-1:0] link;

  mcu_core #(.IMEM_DEPTH(IMEM_DEPTH)) dut0 (
    .clk     (clk),
    .rst_n   (rst_n),
    .tick    (posedge_big_clk),
    .in_pin  (input_signal),
    .out_pin (link)
  );

  mcu_core #(.IMEM_DEPTH(IMEM_DEPTH)) dut1 (
    .clk     (clk),
    .rst_n   (rst_n),
    .tick    (posedge_big_clk),
    .in_pin  (link),
    .out_pin (output_signal)
  );

endmodule

// File: tb/tb_design_a.sv
// Scoreboard bench for design_a: programs are preloaded into both cores' instruction
// memories, expected pin values are queued per scenario and popped on each output change.
module tb_design_a;
  import design_a_pkg::*;

  localparam int DEPTH = 8;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               posedge_big_clk;
  logic signed [10:0] input_signal;
  logic signed [10:0] output_signal;

  design_a #(.IMEM_DEPTH(DEPTH)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .posedge_big_clk (posedge_big_clk),
    .input_signal    (input_signal),
    .output_signal   (output_signal)
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;
  int exp_q[$];

  logic [23:0] prog0 [DEPTH];
  logic [23:0] prog1 [DEPTH];

  always @(posedge clk) cyc <= cyc + 1;

  // Time-unit tick: one clk wide, every 11 clk.
  initial begin
    posedge_big_clk = 1'b0;
    forever begin
      repeat (10) @(negedge clk);
      posedge_big_clk = 1'b1;
      @(negedge clk);
      posedge_big_clk = 1'b0;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input int got, input int want);
    compared++;
    if (got !== want) begin
      mismatched++;
      $display("FAIL %s: got %0d, want %0d", tag, got, want);
    end
  endtask

  function automatic logic [23:0] enc(input cond_e c, input opcode_e op, input src_e s,
                                      input dst_e d, input int imm);
    return {c, op, s, d, 1'b0, imm[10:0]};
  endfunction

  task automatic clear_programs();
    for (int i = 0; i < DEPTH; i++) begin
      prog0[i] = '0;
      prog1[i] = '0;
    end
  endtask

  task automatic load_programs();
    for (int i = 0; i < DEPTH; i++) begin
      dut.dut0.instructionMemory.memory[i] = prog0[i];
      dut.dut1.instructionMemory.memory[i] = prog1[i];
    end
  endtask

  task automatic hold_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    exp_q.delete();
  endtask

  // Wait (bounded) for output_signal to change, then pop and compare against the queue.
  task automatic expect_output(input string tag, input int budget, output int at_cyc);
    logic signed [10:0] prev;
    bit                 seen;
    prev   = output_signal;
    seen   = 1'b0;
    at_cyc = 0;
    for (int n = 0; n < budget && !seen; n++) begin
      @(negedge clk);
      if (output_signal !== prev) seen = 1'b1;
    end
    check({tag, "_seen"}, int'(seen), 1);
    if (seen) begin
      at_cyc = cyc;
      if (exp_q.size() > 0) check(tag, int'(output_signal), exp_q.pop_front());
      else check({tag, "_queued"}, exp_q.size(), 1);
    end
  endtask

  initial begin
    int t, t1, t2, t3, t4, r;
    opcode_e     c_op   [4] = '{OP_TEQ, OP_TEQ, OP_TGT, OP_TLT};
    int          c_imm  [4] = '{5, 6, 4, 4};
    int          c_want [4] = '{1, 2, 1, 2};

    rst_n        = 1'b0;
    input_signal = '0;
    clear_programs();

    // Pass-through chain.
    hold_reset();
    check("rst_out", int'(output_signal), 0);
    check("rst_pc", int'(dut.dut1.program_counter), 0);
    prog0[0] = enc(COND_ALWAYS, OP_MOV, SRC_IN, DST_OUT, 0);
    prog0[1] = enc(COND_ALWAYS, OP_END, SRC_IMM, DST_ACC, 0);
    prog1[0] = prog0[0];
    prog1[1] = prog0[1];
    load_programs();
    input_signal = 11'sd42;
    exp_q.push_back(42);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("pass_core0", int'(dut.dut0.out_pin), 42);
    expect_output("pass_out", 40, t);

    // Saturation of ADD, MUL and MOV, plus the dat register path.
    hold_reset();
    clear_programs();
    prog1[0] = enc(COND_ALWAYS, OP_MOV, SRC_IMM, DST_ACC, 900);
    prog1[1] = enc(COND_ALWAYS, OP_ADD, SRC_IMM, DST_ACC, 500);
    prog1[2] = enc(COND_ALWAYS, OP_MOV, SRC_ACC, DST_OUT, 0);
    prog1[3] = enc(COND_ALWAYS, OP_MOV, SRC_IMM, DST_ACC, 40);
    prog1[4] = enc(COND_ALWAYS, OP_MUL, SRC_IMM, DST_ACC, -30);
    prog1[5] = enc(COND_ALWAYS, OP_MOV, SRC_ACC, DST_OUT, 0);
    prog1[6] = enc(COND_ALWAYS, OP_MOV, SRC_IMM, DST_DAT, 1023);
    prog1[7] = enc(COND_ALWAYS, OP_MOV, SRC_DAT, DST_OUT, 0);
    load_programs();
    input_signal = '0;
    exp_q.push_back(999);
    exp_q.push_back(-999);
    exp_q.push_back(999);
    rst_n = 1'b1;
    expect_output("sat_add", 10, t);
    expect_output("sat_mul", 10, t);
    expect_output("sat_mov", 10, t);

    // Conditional execution on the test flag.
    for (int k = 0; k < 4; k++) begin
      hold_reset();
      clear_programs();
      prog1[0] = enc(COND_ALWAYS, OP_MOV, SRC_IMM, DST_ACC, 5);
      prog1[1] = enc(COND_ALWAYS, c_op[k], SRC_IMM, DST_ACC, c_imm[k]);
      prog1[2] = enc(COND_PLUS, OP_MOV, SRC_IMM, DST_OUT, 1);
      prog1[3] = enc(COND_MINUS, OP_MOV, SRC_IMM, DST_OUT, 2);
      prog1[4] = enc(COND_ALWAYS, OP_END, SRC_IMM, DST_ACC, 0);
      load_programs();
      exp_q.push_back(c_want[k]);
      rst_n = 1'b1;
      expect_output($sformatf("cond_%0d", k), 10, t);
    end

    // Sleep: counter advances once per two ticks.
    hold_reset();
    clear_programs();
    prog1[0] = enc(COND_ALWAYS, OP_ADD, SRC_IMM, DST_ACC, 1);
    prog1[1] = enc(COND_ALWAYS, OP_MOV, SRC_ACC, DST_OUT, 0);
    prog1[2] = enc(COND_ALWAYS, OP_SLP, SRC_IMM, DST_ACC, 2);
    load_programs();
    for (int v = 1; v <= 4; v++) exp_q.push_back(v);
    rst_n = 1'b1;
    expect_output("slp_1", 60, t1);
    expect_output("slp_2", 60, t2);
    expect_output("slp_3", 60, t3);
    expect_output("slp_4", 60, t4);
    check("slp_period_3", t3 - t2, 22);
    check("slp_period_4", t4 - t3, 22);
    repeat (2) @(negedge clk);
    check("slp_cnt", int'(dut.dut1.sleep_cnt), 2);

    // Reset for one clk in the middle of the sleep.
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_out", int'(output_signal), 0);
    check("mid_rst_pc", int'(dut.dut1.program_counter), 0);
    rst_n = 1'b1;
    r = cyc;
    exp_q.push_back(1);
    expect_output("restart", 4, t);
    check("restart_lat", t - r, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
